// File: rtl/jtdd_colmix.sv
`default_nettype none
// ============================================================================
//  Module   : jtdd_colmix
//  Purpose  : Colour mixer behind the char, scroll and object layers. On every
//             pixel clock enable it picks the highest-priority opaque pixel,
//             looks it up in a CPU-writable 512 x 12-bit palette and drives
//             RGB with blanking applied. Pixel-in to RGB-out is exactly two
//             pxl_cen; the blank flags follow the same delay.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          system clock, synchronous active-high reset
//    pxl_cen           pixel clock enable (video pipeline advance)
//    cpu_AB[9:0]       [9] bank select (0 = RG, 1 = B), [8:0] palette entry
//    pal_cs, cpu_wrn   chip select, active-low write strobe
//    cpu_dout[7:0]     CPU write data
//    pal_dout[7:0]     registered CPU read data (holds while pal_cs is low)
//    char_pxl, obj_pxl {pal[3:0], col[3:0]}, transparent when col == 0
//    scr_pxl           scroll pixel, always opaque
//    gfx_en[2:0]       layer enables: [0] char, [1] scroll, [2] obj
//    LHBL, LVBL        active-low blanking inputs
//    LHBL_dly,LVBL_dly blanking aligned to the RGB outputs
//    red/green/blue    4-bit colour outputs
// ============================================================================
module jtdd_colmix #(
  parameter SIMFILE_RG = "pal_rg.bin",
  parameter SIMFILE_B  = "pal_b.bin"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic [9:0] cpu_AB,
  input  logic       pal_cs,
  input  logic       cpu_wrn,
  input  logic [7:0] cpu_dout,
  output logic [7:0] pal_dout,
  input  logic [7:0] char_pxl,
  input  logic [7:0] obj_pxl,
  input  logic [7:0] scr_pxl,
  input  logic [2:0] gfx_en,
  input  logic       LHBL,
  input  logic       LVBL,
  output logic       LHBL_dly,
  output logic       LVBL_dly,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue
);

  localparam logic [8:0] c_BACKDROP = 9'h100;

  // --------------------------------------------------------------------------
  // Palette storage: RG bank holds {green, red}, B bank holds {spare, blue}.
  // Contents survive reset; the preload file names only matter to simulation
  // models that load the arrays externally.
  // --------------------------------------------------------------------------
  logic [7:0] ram_rg [0:511];
  logic [7:0] ram_b  [0:511];

  logic       w_we;
  logic [8:0] w_cpu_addr;
  logic       w_cpu_bank;

  assign w_cpu_addr = cpu_AB[8:0];
  assign w_cpu_bank = cpu_AB[9];
  assign w_we       = pal_cs & ~cpu_wrn;

  always_ff @(posedge clk) begin
    if (w_we && !w_cpu_bank) begin
      ram_rg[w_cpu_addr] <= cpu_dout;
    end
    if (w_we && w_cpu_bank) begin
      ram_b[w_cpu_addr] <= cpu_dout;
    end
  end

  // CPU read port: read-before-write, so a read of the entry being written
  // returns the previous contents.
  logic [7:0] pal_dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_dout_q <= 8'h00;
    end else if (pal_cs) begin
      pal_dout_q <= w_cpu_bank ? ram_b[w_cpu_addr] : ram_rg[w_cpu_addr];
    end
  end

  assign pal_dout = pal_dout_q;

  // --------------------------------------------------------------------------
  // Stage 0: layer priority char > obj > scroll > backdrop.
  // --------------------------------------------------------------------------
  logic [8:0] pal_idx_d;
  logic       w_char_op;
  logic       w_obj_op;

  assign w_char_op = gfx_en[0] && (char_pxl[3:0] != 4'h0);
  assign w_obj_op  = gfx_en[2] && (obj_pxl[3:0]  != 4'h0);

  always_comb begin
    pal_idx_d = c_BACKDROP;
    if (w_char_op) begin
      pal_idx_d = {2'b00, char_pxl[6:0]};
    end else if (w_obj_op) begin
      pal_idx_d = {2'b01, obj_pxl[6:0]};
    end else if (gfx_en[1]) begin
      pal_idx_d = {1'b1, scr_pxl};
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: latch palette index and blanking.
  // --------------------------------------------------------------------------
  logic [8:0] pal_idx_q;
  logic [1:0] bl1_q;
  logic       cen_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pal_idx_q <= 9'h000;
      bl1_q     <= 2'b00;
      cen_dly_q <= 1'b0;
    end else begin
      cen_dly_q <= pxl_cen;
      if (pxl_cen) begin
        pal_idx_q <= pal_idx_d;
        bl1_q     <= {LHBL, LVBL};
      end
    end
  end

  // Video read port. The read is taken once, on the clock after the index
  // changes, and held until stage 2 samples it. This makes a same-clock CPU
  // write to the entry deterministic: this pixel sees the old colour and the
  // next read of that entry sees the new one.
  logic [7:0] vid_rg_q;
  logic [3:0] vid_b_q;

  always_ff @(posedge clk) begin
    if (cen_dly_q) begin
      vid_rg_q <= ram_rg[pal_idx_q];
      vid_b_q  <= ram_b[pal_idx_q][3:0];
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: apply blanking and drive outputs.
  // --------------------------------------------------------------------------
  logic [11:0] rgb_d;
  logic [11:0] rgb_q;
  logic        lhbl_dly_q;
  logic        lvbl_dly_q;

  always_comb begin
    rgb_d = 12'h000;
    if (bl1_q == 2'b11) begin
      rgb_d = {vid_rg_q[3:0], vid_rg_q[7:4], vid_b_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q      <= 12'h000;
      lhbl_dly_q <= 1'b0;
      lvbl_dly_q <= 1'b0;
    end else if (pxl_cen) begin
      rgb_q      <= rgb_d;
      lhbl_dly_q <= bl1_q[1];
      lvbl_dly_q <= bl1_q[0];
    end
  end

  assign red      = rgb_q[11:8];
  assign green    = rgb_q[7:4];
  assign blue     = rgb_q[3:0];
  assign LHBL_dly = lhbl_dly_q;
  assign LVBL_dly = lvbl_dly_q;

  // Bits that are intentionally ignored by the video path.
  logic w_unused;
  assign w_unused = ^{SIMFILE_RG, SIMFILE_B, char_pxl[7], obj_pxl[7]};

endmodule
`default_nettype wire

// File: tb/tb_jtdd_colmix.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jtdd_colmix
//  Purpose  : Self-checking bench for jtdd_colmix. Expected pixels are queued
//             when driven and popped when they reach the outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jtdd_colmix;

  logic       clk = 1'b0;
  logic       rst;
  logic       pxl_cen;
  logic [9:0] cpu_AB;
  logic       pal_cs;
  logic       cpu_wrn;
  logic [7:0] cpu_dout;
  logic [7:0] pal_dout;
  logic [7:0] char_pxl;
  logic [7:0] obj_pxl;
  logic [7:0] scr_pxl;
  logic [2:0] gfx_en;
  logic       LHBL;
  logic       LVBL;
  logic       LHBL_dly;
  logic       LVBL_dly;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;

  jtdd_colmix dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .cpu_AB   (cpu_AB),
    .pal_cs   (pal_cs),
    .cpu_wrn  (cpu_wrn),
    .cpu_dout (cpu_dout),
    .pal_dout (pal_dout),
    .char_pxl (char_pxl),
    .obj_pxl  (obj_pxl),
    .scr_pxl  (scr_pxl),
    .gfx_en   (gfx_en),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] rgb;
    logic        hb;
    logic        vb;
    int          id;
  } exp_t;

  typedef struct {
    logic [7:0] ch;
    logic [7:0] ob;
    logic [7:0] sc;
    logic [2:0] en;
    logic       hb;
    logic       vb;
    logic [8:0] idx;   // palette entry the mixer must select
  } vec_t;

  exp_t       sb[$];
  exp_t       last_out;
  logic [7:0] m_rg [512];
  logic [7:0] m_b  [512];
  int         checks = 0;
  int         errors = 0;
  int         pix_id = 0;
  vec_t       vecs [14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [8:0] idx, input logic hb, input logic vb);
    exp_t e;
    logic [7:0] rg;
    logic [7:0] b;
    rg = m_rg[idx];
    b  = m_b[idx];
    e.rgb = (hb && vb) ? {rg[3:0], rg[7:4], b[3:0]} : 12'h000;
    e.hb  = hb;
    e.vb  = vb;
    e.id  = pix_id;
    return e;
  endfunction

  function automatic logic [15:0] vid_out();
    return {2'b00, LHBL_dly, LVBL_dly, red, green, blue};
  endfunction

  // One pixel period = 4 clocks with pxl_cen on the first. Optionally a CPU
  // write to RG[idx] is placed on the clock where the video read happens.
  task automatic pixel(input logic [7:0] ch, input logic [7:0] ob, input logic [7:0] sc,
                       input logic [2:0] en, input logic hb, input logic vb,
                       input logic [8:0] idx, input logic coll, input logic [7:0] cdat);
    exp_t e;
    exp_t o;
    e = mk_exp(idx, hb, vb);
    sb.push_back(e);
    pix_id++;
    @(negedge clk);
    char_pxl = ch; obj_pxl = ob; scr_pxl = sc; gfx_en = en;
    LHBL = hb; LVBL = vb; pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    if (sb.size() >= 2) begin
      o = sb.pop_front();
      chk($sformatf("pixel%0d", o.id), vid_out(), {2'b00, o.hb, o.vb, o.rgb});
      last_out = o;
    end
    if (coll) begin
      pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_AB = {1'b0, idx}; cpu_dout = cdat;
      m_rg[idx] = cdat;
    end
    @(posedge clk); #1;
    pal_cs = 1'b0; cpu_wrn = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic filler();
    pixel(8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 9'h100, 1'b0, 8'h00);
  endtask

  task automatic cpu_write(input logic [9:0] addr, input logic [7:0] data);
    @(negedge clk);
    pal_cs = 1'b1; cpu_wrn = 1'b0; cpu_AB = addr; cpu_dout = data;
    @(posedge clk); #1;
    pal_cs = 1'b0; cpu_wrn = 1'b1;
    if (addr[9]) m_b[addr[8:0]] = data;
    else         m_rg[addr[8:0]] = data;
  endtask

  task automatic cpu_read(input string name, input logic [9:0] addr, input logic [7:0] exp);
    @(negedge clk);
    pal_cs = 1'b1; cpu_wrn = 1'b1; cpu_AB = addr;
    @(posedge clk); #1;
    chk(name, {8'h00, pal_dout}, {8'h00, exp});
    pal_cs = 1'b0;
  endtask

  task automatic reset_pipe_expect();
    exp_t z;
    sb.delete();
    z.rgb = 12'h000; z.hb = 1'b0; z.vb = 1'b0; z.id = -1;
    sb.push_back(z);
  endtask

  initial begin
    vecs[0]  = '{8'h05, 8'h00, 8'h00, 3'b111, 1'b1, 1'b1, 9'h005};
    vecs[1]  = '{8'h30, 8'hC9, 8'h00, 3'b111, 1'b1, 1'b1, 9'h0C9};
    vecs[2]  = '{8'h00, 8'h00, 8'hFF, 3'b111, 1'b1, 1'b1, 9'h1FF};
    vecs[3]  = '{8'h00, 8'h00, 8'hFF, 3'b000, 1'b1, 1'b1, 9'h100};
    vecs[4]  = '{8'h85, 8'h12, 8'h33, 3'b111, 1'b1, 1'b1, 9'h005};
    vecs[5]  = '{8'h85, 8'h12, 8'h33, 3'b110, 1'b1, 1'b1, 9'h092};
    vecs[6]  = '{8'h85, 8'h12, 8'h33, 3'b010, 1'b1, 1'b1, 9'h133};
    vecs[7]  = '{8'h85, 8'h12, 8'h33, 3'b100, 1'b1, 1'b1, 9'h092};
    vecs[8]  = '{8'h85, 8'h10, 8'h33, 3'b100, 1'b1, 1'b1, 9'h100};
    vecs[9]  = '{8'h7F, 8'hFF, 8'h00, 3'b111, 1'b1, 1'b1, 9'h07F};
    vecs[10] = '{8'h00, 8'hFF, 8'h01, 3'b111, 1'b1, 1'b1, 9'h0FF};
    vecs[11] = '{8'h00, 8'h00, 8'h00, 3'b010, 1'b1, 1'b1, 9'h100};
    vecs[12] = '{8'h05, 8'h00, 8'h00, 3'b111, 1'b0, 1'b1, 9'h005};
    vecs[13] = '{8'h05, 8'h00, 8'h00, 3'b111, 1'b1, 1'b0, 9'h005};

    rst = 1'b1; pxl_cen = 1'b1; cpu_AB = '0; pal_cs = 1'b0; cpu_wrn = 1'b1;
    cpu_dout = '0; char_pxl = '0; obj_pxl = '0; scr_pxl = '0; gfx_en = 3'b111;
    LHBL = 1'b1; LVBL = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_video", vid_out(), 16'h0000);
    chk("reset_pal_dout", {8'h00, pal_dout}, 16'h0000);
    @(negedge clk);
    rst = 1'b0; pxl_cen = 1'b0;
    reset_pipe_expect();

    // Fill both banks with random data, then the named entries.
    for (int a = 0; a < 1024; a++) cpu_write(10'(a), 8'($urandom));
    cpu_write(10'h005, 8'hA3);
    cpu_write(10'h205, 8'h07);
    cpu_write(10'h0C9, 8'h21);
    cpu_write(10'h2C9, 8'h04);
    cpu_write(10'h233, 8'h5C);
    cpu_read("rd_rg_005", 10'h005, 8'hA3);
    cpu_read("rd_b_005", 10'h205, 8'h07);
    cpu_read("rd_b_upper", 10'h233, 8'h5C);

    for (int i = 0; i < 14; i++)
      pixel(vecs[i].ch, vecs[i].ob, vecs[i].sc, vecs[i].en, vecs[i].hb, vecs[i].vb,
            vecs[i].idx, 1'b0, 8'h00);

    // Literal colours from the palette writes above.
    pixel(8'h05, 8'h00, 8'h00, 3'b111, 1'b1, 1'b1, 9'h005, 1'b0, 8'h00);
    pixel(8'h30, 8'hC9, 8'h00, 3'b111, 1'b1, 1'b1, 9'h0C9, 1'b0, 8'h00);
    chk("char_005_rgb", {4'h0, red, green, blue}, 16'h03A7);
    filler();
    chk("obj_0C9_rgb", {4'h0, red, green, blue}, 16'h0124);

    // Horizontal blank for pixels 2..4.
    for (int i = 0; i < 8; i++)
      pixel(8'h05, 8'h00, 8'h00, 3'b111, !(i >= 2 && i <= 4), 1'b1, 9'h005, 1'b0, 8'h00);
    filler();

    // CPU write to RG[0C9] on the same clock video reads it.
    pixel(8'h00, 8'hC9, 8'h00, 3'b111, 1'b1, 1'b1, 9'h0C9, 1'b1, 8'h5E);
    pixel(8'h00, 8'hC9, 8'h00, 3'b111, 1'b1, 1'b1, 9'h0C9, 1'b0, 8'h00);
    chk("collide_old", {4'h0, red, green, blue}, 16'h0124);
    filler();
    chk("collide_new", {4'h0, red, green, blue}, 16'h0E54);

    // Reset mid-line, with pxl_cen also high.
    pixel(8'h05, 8'h00, 8'h00, 3'b111, 1'b1, 1'b1, 9'h005, 1'b0, 8'h00);
    pixel(8'h05, 8'h00, 8'h00, 3'b111, 1'b1, 1'b1, 9'h005, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1; pxl_cen = 1'b1; pal_cs = 1'b1; cpu_AB = 10'h005;
    @(posedge clk); #1;
    chk("midreset_video", vid_out(), 16'h0000);
    chk("midreset_pal_dout", {8'h00, pal_dout}, 16'h0000);
    @(negedge clk);
    rst = 1'b0; pxl_cen = 1'b0; pal_cs = 1'b0;
    reset_pipe_expect();
    cpu_read("rd_after_reset", 10'h005, 8'hA3);
    cpu_read("rd_after_reset_b", 10'h205, 8'h07);
    pixel(8'h05, 8'h00, 8'h00, 3'b111, 1'b1, 1'b1, 9'h005, 1'b0, 8'h00);
    chk("post_reset_flushed", vid_out(), 16'h0000);
    filler();
    chk("post_reset_valid", vid_out(), 16'h33A7);

    // Outputs freeze while pxl_cen is low; pal_dout holds while pal_cs is low.
    repeat (12) @(posedge clk);
    #1;
    chk("freeze", vid_out(), {2'b00, last_out.hb, last_out.vb, last_out.rgb});
    cpu_read("rd_0C9_new", 10'h0C9, 8'h5E);
    @(negedge clk);
    cpu_AB = 10'h005;
    @(posedge clk); #1;
    chk("pal_dout_hold", {8'h00, pal_dout}, 16'h005E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
